secded16_encoder_pipe: RTL

- Upstream neighbour of the 16-bit SEC/DED corrector: converts a stream of 16-bit data words into 22-bit Hamming SEC/DED codewords, which the corrector later checks and repairs.
- Two-stage elastic pipeline with valid/ready handshakes on both sides.
- A one-shot error-injection register lets a bench corrupt one outgoing codeword, to exercise single-error correction and double-error detection in the corrector.
- A running count of emitted codewords is kept.

---
 rtl/secded16_pkg.sv | 38 +++
 rtl/secded16_encoder_pipe_if.sv | 27 ++
 rtl/secded16_chk_gen.sv | 11 +
 rtl/secded16_encoder_pipe.sv | 100 ++++++++++
 4 files changed

// File: rtl/secded16_pkg.sv
// Shared definitions for the 16-bit SEC/DED code: widths, Hamming position
// table and the golden check-bit function used by encoder and corrector.
package secded16_pkg;

  localparam int DATA_W = 16;
  localparam int CHK_W  = 6;
  localparam int CW_W   = DATA_W + CHK_W;

  // Index of each check bit inside chk[5:0] = {p0, p16, p8, p4, p2, p1}.
  localparam int P1  = 0;
  localparam int P2  = 1;
  localparam int P4  = 2;
  localparam int P8  = 3;
  localparam int P16 = 4;
  localparam int P0  = 5;

  typedef logic [4:0] pos_t;

  // Hamming position of data bit d0..d15 (powers of two are reserved for pK).
  localparam pos_t DATA_POS [DATA_W] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  function automatic logic [CHK_W-1:0] secded16_check(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] chk;
    chk = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < 5; k++) begin
        if (DATA_POS[i][k]) chk[k] = chk[k] ^ data[i];
      end
    end
    // Overall parity covers data and p1..p16 so the full word has even weight.
    chk[P0] = (^data) ^ (^chk[P16:P1]);
    return chk;
  endfunction

endpackage

// File: rtl/secded16_encoder_pipe_if.sv
// Stream, injection and status signals of the SEC/DED encoder pipeline.
interface secded16_encoder_pipe_if;
  import secded16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   out_cw;
  logic              out_injected;
  logic              inj_arm;
  logic [CW_W-1:0]   inj_mask;
  logic              inj_armed;
  logic [15:0]       cw_count;

  modport master (
    output in_valid, in_data, out_ready, inj_arm, inj_mask,
    input  in_ready, out_valid, out_cw, out_injected, inj_armed, cw_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, inj_arm, inj_mask,
    output in_ready, out_valid, out_cw, out_injected, inj_armed, cw_count
  );

endinterface

// File: rtl/secded16_chk_gen.sv
// Combinational check-bit generator: 16 data bits -> {p0, p16, p8, p4, p2, p1}.
module secded16_chk_gen
  import secded16_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CHK_W-1:0]  o_chk
);

  assign o_chk = secded16_check(i_data);

endmodule

// File: rtl/secded16_encoder_pipe.sv
// Two-stage elastic SEC/DED encoder with one-shot error injection and an
// emitted-codeword counter.
module secded16_encoder_pipe
  import secded16_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  secded16_encoder_pipe_if.slave bus
);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s2_valid;
  logic [CW_W-1:0]   r_s2_cw;
  logic              r_s2_inj;
  logic              r_inj_armed;
  logic [CW_W-1:0]   r_inj_mask;
  logic [15:0]       r_cw_count;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [CHK_W-1:0]  w_chk;
  logic [CW_W-1:0]   w_enc_cw;
  logic [CW_W-1:0]   w_s2_next_cw;

  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_adv;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_s2_valid && bus.out_ready;

  secded16_chk_gen u_chk_gen (
    .i_data (r_s1_data),
    .o_chk  (w_chk)
  );

  assign w_enc_cw     = {w_chk, r_s1_data};
  assign w_s2_next_cw = r_inj_armed ? (w_enc_cw ^ r_inj_mask) : w_enc_cw;

  // NOTE: every register below uses <= so all stages sample pre-edge values;
  // blocking assignments here would let S2 see S1's new word in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= bus.in_data;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Codeword and flag only change on a transfer, so they stay put under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_cw    <= '0;
      r_s2_inj   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_cw    <= w_s2_next_cw;
      r_s2_inj   <= r_inj_armed;
    end else if (w_s2_adv) begin
      r_s2_valid <= 1'b0;
    end
  end

  // A new arm wins over consumption: a same-cycle transfer already used the old mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_armed <= 1'b0;
      r_inj_mask  <= '0;
    end else if (bus.inj_arm) begin
      r_inj_armed <= 1'b1;
      r_inj_mask  <= bus.inj_mask;
    end else if (w_s1_adv && r_inj_armed) begin
      r_inj_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw_count <= '0;
    end else if (w_out_fire) begin
      r_cw_count <= r_cw_count + 16'd1;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_s2_valid;
  assign bus.out_cw       = r_s2_cw;
  assign bus.out_injected = r_s2_inj;
  assign bus.inj_armed    = r_inj_armed;
  assign bus.cw_count     = r_cw_count;

endmodule
